fetch_stream: RTL and testbench



---
 rtl/fetch_stream.sv | 136 +++++++++++++
 tb/tb_fetch_stream.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stream.sv
// fetch_stream: per-path instruction fetch sequencer.
// Keeps a PC, issues one fetch request at a time, and collects the matching response.
// Each completed instruction is tagged with its PC and stored in a small FIFO.
// The decode stage drains that FIFO through a valid/ready handshake.
// A redirect flushes the FIFO. It also discards a response that is still in flight.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_i                    stage enable; 0 freezes all state
//   redirect_valid_i/pc_i   one-cycle branch redirect and its target
//   fetch_req_pc_o/valid_o  registered fetch request {pc, valid}
//   fetch_rsp_inst_i/done_i fetch response {inst, done}
//   out_valid_o/inst_o/pc_o FIFO head towards decode
//   out_ready_i             decode accepts the head this cycle
module fetch_stream #(
    parameter int unsigned BufDepth = 4,
    parameter logic [31:0] ResetPc  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_req_pc_o,
    output logic        fetch_req_valid_o,
    input  logic [31:0] fetch_rsp_inst_i,
    input  logic        fetch_rsp_done_i,
    output logic        out_valid_o,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    input  logic        out_ready_i
);

    localparam int unsigned PtrW = $clog2(BufDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(BufDepth);

    typedef enum logic [1:0] {StGap, StIssue, StFlush, StStall} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     saved_pc_q, saved_pc_d;
    logic [31:0]     req_pc_q;
    logic            req_valid_q;
    logic [31:0]     pc_mem_q   [BufDepth];
    logic [31:0]     inst_mem_q [BufDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d, cnt_after_pop;
    logic            flush, push, pop;

    // A redirect cancels any push or pop in the same cycle.
    assign flush = en_i & redirect_valid_i;
    assign pop   = en_i & (count_q != '0) & out_ready_i & ~flush;
    // Occupancy seen by GAP/STALL: after this cycle's pop and flush (they never push).
    assign cnt_after_pop = flush ? '0 : count_q - CntW'(pop);
    assign count_d       = flush ? '0 : count_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        saved_pc_d = saved_pc_q;
        push       = 1'b0;
        if (en_i) begin
            unique case (state_q)
                StIssue: begin
                    if (fetch_rsp_done_i) begin
                        push    = ~redirect_valid_i;
                        pc_d    = redirect_valid_i ? redirect_pc_i : pc_q + 32'd4;
                        state_d = StGap;
                    end else if (redirect_valid_i) begin
                        // Keep the request up until the stale response returns.
                        saved_pc_d = redirect_pc_i;
                        state_d    = StFlush;
                    end
                end
                StFlush: begin
                    if (fetch_rsp_done_i) begin
                        pc_d    = redirect_valid_i ? redirect_pc_i : saved_pc_q;
                        state_d = StGap;
                    end else if (redirect_valid_i) begin
                        saved_pc_d = redirect_pc_i;
                    end
                end
                StGap, StStall: begin
                    if (redirect_valid_i) begin
                        pc_d = redirect_pc_i;
                    end
                    state_d = (cnt_after_pop < DepthCnt) ? StIssue : StStall;
                end
                default: state_d = StGap;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StGap;
            pc_q        <= ResetPc;
            saved_pc_q  <= '0;
            req_pc_q    <= ResetPc;
            req_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < BufDepth; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            saved_pc_q  <= saved_pc_d;
            req_pc_q    <= pc_d;
            req_valid_q <= (state_d == StIssue) || (state_d == StFlush);
            count_q     <= count_d;
            if (push && !flush) begin
                pc_mem_q[wr_ptr_q]   <= pc_q;
                inst_mem_q[wr_ptr_q] <= fetch_rsp_inst_i;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign fetch_req_pc_o    = req_pc_q;
    assign fetch_req_valid_o = req_valid_q;
    assign out_valid_o       = (count_q != '0);
    assign out_pc_o          = pc_mem_q[rd_ptr_q];
    assign out_inst_o        = inst_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stream.sv
// Testbench for fetch_stream.
// Directed scenarios are followed by a randomized run.
// The randomized run is checked against a transaction-level queue model.
module tb_fetch_stream;

    localparam logic [31:0] ResetPc = 32'h0000_0100;
    localparam int Depth = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] fetch_req_pc_o;
    logic        fetch_req_valid_o;
    logic [31:0] fetch_rsp_inst_i;
    logic        fetch_rsp_done_i;
    logic        out_valid_o;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        out_ready_i;

    int checks = 0;
    int failures = 0;

    fetch_stream #(
        .BufDepth (Depth),
        .ResetPc  (ResetPc)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .fetch_req_pc_o    (fetch_req_pc_o),
        .fetch_req_valid_o (fetch_req_valid_o),
        .fetch_rsp_inst_i  (fetch_rsp_inst_i),
        .fetch_rsp_done_i  (fetch_rsp_done_i),
        .out_valid_o       (out_valid_o),
        .out_inst_o        (out_inst_o),
        .out_pc_o          (out_pc_o),
        .out_ready_i       (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Fetch responder: raises done `lat` cycles into a request and holds it until valid drops.
    logic        resp_on = 1'b0;
    int          lat = 2;
    int          rcnt = 0;
    logic        auto_done = 1'b0;
    logic [31:0] auto_inst = '0;
    logic        man_done;
    logic [31:0] man_inst;
    logic [31:0] inst_of [logic [31:0]];

    assign fetch_rsp_done_i = resp_on ? auto_done : man_done;
    assign fetch_rsp_inst_i = resp_on ? auto_inst : man_inst;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni || !fetch_req_valid_o) begin
                auto_done = 1'b0;
                rcnt      = 0;
            end else if (!auto_done) begin
                rcnt++;
                if (rcnt >= lat) begin
                    auto_done = 1'b1;
                    auto_inst = $urandom;
                    inst_of[fetch_req_pc_o] = auto_inst;
                end
            end
        end
    end

    // Observer: records popped entries, issued request PCs and idle cycles before each request.
    ent_t        got_q[$];
    logic [31:0] req_q[$];
    int          gap_q[$];
    logic        obs_prev_v = 1'b0;
    int          low_run = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                obs_prev_v = 1'b0;
                low_run    = 0;
            end else begin
                if (en_i && out_valid_o && out_ready_i && !redirect_valid_i)
                    got_q.push_back({out_pc_o, out_inst_o});
                if (fetch_req_valid_o && !obs_prev_v) begin
                    req_q.push_back(fetch_req_pc_o);
                    gap_q.push_back(low_run);
                end
                if (fetch_req_valid_o) low_run = 0;
                else low_run++;
                obs_prev_v = fetch_req_valid_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic do_reset(input logic auto_mode, input int l);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        en_i = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        out_ready_i = 1'b0;
        man_done = 1'b0;
        man_inst = '0;
        resp_on = auto_mode;
        lat = l;
        step(2);
        got_q.delete();
        req_q.delete();
        gap_q.delete();
        inst_of.delete();
        rst_ni = 1'b1;
    endtask

    function automatic int find_req(input logic [31:0] pc);
        for (int i = 0; i < req_q.size(); i++) if (req_q[i] == pc) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        step(2);
        checks++; if (fetch_req_valid_o !== 1'b0) begin failures++;
            $display("FAIL reset_req_valid got=%b exp=0", fetch_req_valid_o); end
        checks++; if (fetch_req_pc_o !== ResetPc) begin failures++;
            $display("FAIL reset_req_pc got=%h exp=%h", fetch_req_pc_o, ResetPc); end
        checks++; if (out_valid_o !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        checks++; if (out_pc_o !== 32'h0) begin failures++;
            $display("FAIL reset_out_pc got=%h exp=0", out_pc_o); end
        checks++; if (out_inst_o !== 32'h0) begin failures++;
            $display("FAIL reset_out_inst got=%h exp=0", out_inst_o); end
    endtask

    task automatic test_sequence();
        int t = 0;
        do_reset(1'b1, 2);
        out_ready_i = 1'b1;
        while (got_q.size() < 3 && t < 60) begin step(1); t++; end
        checks++; if (got_q.size() < 3) begin failures++;
            $display("FAIL seq_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            logic [31:0] epc = ResetPc + 32'(4 * i);
            checks++; if (got_q[i].pc !== epc) begin failures++;
                $display("FAIL seq_pc[%0d] got=%h exp=%h", i, got_q[i].pc, epc); end
            checks++; if (!inst_of.exists(epc) || got_q[i].inst !== inst_of[epc]) begin failures++;
                $display("FAIL seq_inst[%0d] got=%h", i, got_q[i].inst); end
        end
        for (int i = 1; i < 3 && i < gap_q.size(); i++) begin
            checks++; if (gap_q[i] != 1) begin failures++;
                $display("FAIL seq_gap[%0d] got=%0d exp=1", i, gap_q[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b1, 2);
        step(26);
        checks++; if (req_q.size() != Depth) begin failures++;
            $display("FAIL stall_reqs got=%0d exp=%0d", req_q.size(), Depth); end
        checks++; if (fetch_req_valid_o !== 1'b0) begin failures++;
            $display("FAIL stall_req_valid got=%b exp=0", fetch_req_valid_o); end
        checks++; if (out_valid_o !== 1'b1 || out_pc_o !== ResetPc) begin failures++;
            $display("FAIL stall_head got=%b/%h exp=1/%h", out_valid_o, out_pc_o, ResetPc); end
        out_ready_i = 1'b1;
        step(1);
        out_ready_i = 1'b0;
        step(4);
        checks++; if (got_q.size() != 1) begin failures++;
            $display("FAIL stall_pops got=%0d exp=1", got_q.size()); end
        checks++; if (out_pc_o !== ResetPc + 32'd4) begin failures++;
            $display("FAIL stall_new_head got=%h exp=%h", out_pc_o, ResetPc + 32'd4); end
        checks++; if (req_q.size() != 5 || req_q[req_q.size() - 1] !== ResetPc + 32'd16) begin
            failures++; $display("FAIL stall_next_req got=%0d reqs exp=5 at %h",
                                 req_q.size(), ResetPc + 32'd16); end
    endtask

    task automatic test_redirect_outstanding();
        int t = 0;
        int idx;
        bit seen_stale = 0;
        do_reset(1'b1, 4);
        out_ready_i = 1'b1;
        while (!(fetch_req_valid_o && fetch_req_pc_o == ResetPc + 32'd8) && t < 80) begin
            step(1); t++;
        end
        checks++; if (!(fetch_req_valid_o && fetch_req_pc_o == ResetPc + 32'd8)) begin failures++;
            $display("FAIL redir_wait got=%h exp=%h", fetch_req_pc_o, ResetPc + 32'd8); end
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h400;
        step(1);
        redirect_valid_i = 1'b0;
        checks++; if (fetch_req_valid_o !== 1'b1 || fetch_req_pc_o !== ResetPc + 32'd8) begin
            failures++; $display("FAIL redir_hold got=%b/%h exp=1/%h",
                                 fetch_req_valid_o, fetch_req_pc_o, ResetPc + 32'd8); end
        step(20);
        foreach (got_q[i]) if (got_q[i].pc == ResetPc + 32'd8) seen_stale = 1;
        checks++; if (seen_stale) begin failures++;
            $display("FAIL redir_stale got=present exp=absent"); end
        checks++; if (got_q.size() < 3 || got_q[2].pc !== 32'h400) begin failures++;
            $display("FAIL redir_first got=%0d entries exp=3rd at 400", got_q.size()); end
        idx = find_req(ResetPc + 32'd8);
        checks++; if (idx < 0 || idx + 1 >= req_q.size() || req_q[idx + 1] !== 32'h400) begin
            failures++; $display("FAIL redir_next_req idx=%0d exp=400", idx); end
        else begin
            checks++; if (gap_q[idx + 1] != 1) begin failures++;
                $display("FAIL redir_gap got=%0d exp=1", gap_q[idx + 1]); end
        end
    endtask

    task automatic test_redirect_same();
        int t = 0;
        int idx;
        do_reset(1'b1, 2);
        while (!(auto_done && fetch_req_valid_o && fetch_req_pc_o == ResetPc + 32'd8) && t < 80) begin
            step(1); t++;
        end
        checks++; if (out_valid_o !== 1'b1) begin failures++;
            $display("FAIL same_prefill got=%b exp=1", out_valid_o); end
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h800;
        step(1);
        redirect_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin failures++;
            $display("FAIL same_flushed got=%b exp=0", out_valid_o); end
        step(8);
        out_ready_i = 1'b1;
        step(10);
        checks++; if (got_q.size() < 1 || got_q[0].pc !== 32'h800) begin failures++;
            $display("FAIL same_first got=%0d entries exp=first at 800", got_q.size()); end
        idx = find_req(ResetPc + 32'd8);
        checks++; if (idx < 0 || idx + 1 >= req_q.size() || req_q[idx + 1] !== 32'h800) begin
            failures++; $display("FAIL same_next_req idx=%0d exp=800", idx); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 2);
        out_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step(1);
        redirect_valid_i = 1'b0;
        step(14);
        checks++; if (req_q.size() < 2 || req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
            failures++; $display("FAIL wrap_reqs got=%0d reqs exp=FFFFFFFC then 0", req_q.size()); end
        checks++; if (got_q.size() < 2 || got_q[1].pc !== 32'h0 || !inst_of.exists(32'h0)
                      || got_q[1].inst !== inst_of[32'h0]) begin
            failures++; $display("FAIL wrap_out got=%0d entries exp=pc 0 second", got_q.size()); end
    endtask

    task automatic test_enable();
        do_reset(1'b0, 0);
        out_ready_i = 1'b1;
        step(1);
        en_i = 1'b0;
        man_done = 1'b1;
        man_inst = 32'hCAFE_F00D;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h900;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (fetch_req_valid_o !== 1'b1 || fetch_req_pc_o !== ResetPc
                          || out_valid_o !== 1'b0) begin
                failures++; $display("FAIL en_freeze_issue[%0d] got=%b/%h/%b exp=1/%h/0", i,
                                     fetch_req_valid_o, fetch_req_pc_o, out_valid_o, ResetPc); end
        end
        en_i = 1'b1;
        redirect_valid_i = 1'b0;
        step(1);
        man_done = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || out_pc_o !== ResetPc || out_inst_o !== 32'hCAFE_F00D)
        begin failures++; $display("FAIL en_push got=%b/%h/%h exp=1/%h/cafef00d",
                                   out_valid_o, out_pc_o, out_inst_o, ResetPc); end
        en_i = 1'b0;
        man_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (out_valid_o !== 1'b1 || fetch_req_valid_o !== 1'b0) begin failures++;
                $display("FAIL en_freeze_gap[%0d] got=%b/%b exp=1/0", i, out_valid_o,
                         fetch_req_valid_o); end
        end
        checks++; if (got_q.size() != 0) begin failures++;
            $display("FAIL en_no_pop got=%0d exp=0", got_q.size()); end
        man_done = 1'b0;
        en_i = 1'b1;
        step(1);
        checks++; if (fetch_req_valid_o !== 1'b1 || fetch_req_pc_o !== ResetPc + 32'd4
                      || got_q.size() != 1) begin
            failures++; $display("FAIL en_resume got=%b/%h/%0d exp=1/%h/1", fetch_req_valid_o,
                                 fetch_req_pc_o, got_q.size(), ResetPc + 32'd4); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 0);
        step(1);
        man_done = 1'b1;
        man_inst = 32'h0000_1234;
        step(1);
        man_done = 1'b0;
        step(1);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h400;
        step(1);
        redirect_valid_i = 1'b0;
        checks++; if (fetch_req_valid_o !== 1'b1 || fetch_req_pc_o !== ResetPc + 32'd4) begin
            failures++; $display("FAIL flush_hold got=%b/%h exp=1/%h", fetch_req_valid_o,
                                 fetch_req_pc_o, ResetPc + 32'd4); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (fetch_req_valid_o !== 1'b0 || fetch_req_pc_o !== ResetPc) begin failures++;
            $display("FAIL async_req got=%b/%h exp=0/%h", fetch_req_valid_o, fetch_req_pc_o,
                     ResetPc); end
        checks++; if (out_valid_o !== 1'b0 || out_pc_o !== 32'h0 || out_inst_o !== 32'h0) begin
            failures++; $display("FAIL async_out got=%b/%h/%h exp=0/0/0", out_valid_o, out_pc_o,
                                 out_inst_o); end
    endtask

    task automatic test_random();
        ent_t        mq[$];
        logic [31:0] m_next_pc = ResetPc;
        logic [31:0] m_cur_pc = '0;
        logic [31:0] m_saved = '0;
        bit          m_stale = 0;
        logic        m_prev_v = 1'b0;
        do_reset(1'b1, 2);
        for (int c = 0; c < 800; c++) begin
            @(posedge clk_i);
            #2;
            out_ready_i = ($urandom_range(0, 3) != 0);
            en_i = ($urandom_range(0, 7) != 0);
            redirect_valid_i = ($urandom_range(0, 11) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            lat = $urandom_range(1, 4);
            @(negedge clk_i);
            checks++; if (out_valid_o !== (mq.size() != 0)) begin failures++;
                $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid_o, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if ({out_pc_o, out_inst_o} !== mq[0]) begin failures++;
                    $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", c, out_pc_o, out_inst_o,
                             mq[0].pc, mq[0].inst); end
            end
            if (fetch_req_valid_o && !m_prev_v) begin
                checks++; if (fetch_req_pc_o !== m_next_pc || mq.size() >= Depth) begin
                    failures++; $display("FAIL rnd_req[%0d] got=%h exp=%h occ=%0d", c,
                                         fetch_req_pc_o, m_next_pc, mq.size()); end
                m_cur_pc = m_next_pc;
            end
            m_prev_v = fetch_req_valid_o;
            if (en_i) begin
                if (redirect_valid_i) mq.delete();
                else if (out_ready_i && mq.size() != 0) void'(mq.pop_front());
                if (fetch_req_valid_o && fetch_rsp_done_i) begin
                    if (!m_stale && !redirect_valid_i) mq.push_back({m_cur_pc, fetch_rsp_inst_i});
                    m_next_pc = redirect_valid_i ? redirect_pc_i :
                                m_stale ? m_saved : m_cur_pc + 32'd4;
                    m_stale = 0;
                end else if (fetch_req_valid_o && redirect_valid_i) begin
                    m_stale = 1;
                    m_saved = redirect_pc_i;
                end else if (!fetch_req_valid_o && redirect_valid_i) begin
                    m_next_pc = redirect_pc_i;
                end
            end
        end
    endtask

    initial begin
        en_i = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        out_ready_i = 1'b0;
        man_done = 1'b0;
        man_inst = '0;
        rst_ni = 1'b1;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_outstanding();
        test_redirect_same();
        test_wrap();
        test_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
